// File: rtl/param_alu.sv
// Parameterized ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// signed shift-add multiplier (MUL/MLA) with a hidden high-half register.
module param_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             flush,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg
);
  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
                         OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                         OP_LSL = 4'h8, OP_LSR = 4'h9, OP_ASR = 4'hA, OP_ROR = 4'hB,
                         OP_MUL = 4'hC, OP_MLA = 4'hD, OP_MRT = 4'hE, OP_PAS = 4'hF;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } req_t;

  state_t               state, state_nxt;
  req_t                 req;
  logic [2*WIDTH-1:0]   acc, mcand, prod;
  logic [WIDTH-1:0]     mplier, hi;
  logic [CW-1:0]        cnt;
  logic                 prod_neg;
  logic                 accept, is_mul, mul_last;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     res_nxt, hi_nxt;
  logic                 carry_nxt;
  logic [WIDTH:0]       arith;
  logic [2*WIDTH:0]     mla;
  logic [SHW-1:0]       rot_amt;
  logic                 big;

  assign in_ready = (state == IDLE) && !done;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL) || (op == OP_MLA);
  assign mul_last = (cnt == CW'(WIDTH - 1));
  // Two's-complement negate of -2^(W-1) yields 2^(W-1), which is the correct
  // unsigned magnitude, so no extra bit is needed.
  assign mag_a    = a[WIDTH-1] ? -a : a;
  assign mag_b    = b[WIDTH-1] ? -b : b;
  assign rot_amt  = SHW'(32'(req.b[SHW-1:0]) % WIDTH);
  assign big      = 32'(req.b) >= WIDTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul ? MUL : DONE;
      MUL:     if (flush) state_nxt = IDLE;
               else if (mul_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_nxt   = req.a;
    hi_nxt    = hi;
    carry_nxt = carry;
    arith     = '0;
    prod      = prod_neg ? -acc : acc;
    mla       = {1'b0, prod} + {1'b0, {WIDTH{req.c[WIDTH-1]}}, req.c};
    case (req.op)
      OP_ADD: begin
        arith = {1'b0, req.a} + {1'b0, req.b};
        {carry_nxt, res_nxt} = arith;
      end
      OP_ADC: begin
        arith = {1'b0, req.a} + {1'b0, req.b} + {{WIDTH{1'b0}}, carry};
        {carry_nxt, res_nxt} = arith;
      end
      // carry is the inverted borrow: set when no underflow occurred
      OP_SUB: begin
        arith     = {1'b0, req.a} - {1'b0, req.b};
        res_nxt   = arith[WIDTH-1:0];
        carry_nxt = !arith[WIDTH];
      end
      OP_SBC: begin
        arith     = {1'b0, req.a} - {1'b0, req.b} - {{WIDTH{1'b0}}, !carry};
        res_nxt   = arith[WIDTH-1:0];
        carry_nxt = !arith[WIDTH];
      end
      OP_AND: res_nxt = req.a & req.b;
      OP_OR:  res_nxt = req.a | req.b;
      OP_XOR: res_nxt = req.a ^ req.b;
      OP_NOT: res_nxt = ~req.a;
      OP_LSL: res_nxt = big ? '0 : req.a << req.b;
      OP_LSR: res_nxt = big ? '0 : req.a >> req.b;
      OP_ASR: res_nxt = big ? {WIDTH{req.a[WIDTH-1]}} : WIDTH'($signed(req.a) >>> req.b);
      OP_ROR: res_nxt = WIDTH'({req.a, req.a} >> rot_amt);
      OP_MUL: begin
        res_nxt   = prod[WIDTH-1:0];
        hi_nxt    = prod[2*WIDTH-1:WIDTH];
        carry_nxt = 1'b0;
      end
      OP_MLA: begin
        res_nxt   = mla[WIDTH-1:0];
        hi_nxt    = mla[2*WIDTH-1:WIDTH];
        carry_nxt = mla[2*WIDTH];
      end
      OP_MRT: res_nxt = hi;
      OP_PAS: res_nxt = req.a;
      default: res_nxt = req.a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      prod_neg <= 1'b0;
      result   <= '0;
      hi       <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
      neg      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        req      <= '{op: op, a: a, b: b, c: c};
        acc      <= '0;
        mcand    <= {{WIDTH{1'b0}}, mag_a};
        mplier   <= mag_b;
        cnt      <= '0;
        prod_neg <= a[WIDTH-1] ^ b[WIDTH-1];
      end else if (state == MUL) begin
        // one multiplier bit per cycle; sign is applied once in DONE
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end else if (state == DONE) begin
        result <= res_nxt;
        hi     <= hi_nxt;
        carry  <= carry_nxt;
        zero   <= (res_nxt == '0);
        neg    <= res_nxt[WIDTH-1];
        done   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu (WIDTH=16): reference model pushes expected
// results at issue time; they are popped and compared when done pulses.
module tb_param_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, flush, done;
  logic [3:0]   op;
  logic [W-1:0] a, b, c, result;
  logic         carry, zero, neg;

  param_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c(c), .flush(flush), .done(done),
    .result(result), .carry(carry), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         cy, z, n;
    int           acc, lat;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_fail = 0;
  logic [W-1:0] m_hi = '0, m_res = '0;
  logic         m_carry = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic, native signed multiply.
  task automatic model(input logic [3:0] o, input logic [W-1:0] xa, xb, xc,
                       output logic [W-1:0] r);
    logic [W:0]    s;
    logic [32:0]   s33;
    logic [31:0]   cx;
    longint        p;
    logic          bw;
    r = xa;
    case (o)
      4'h0: begin s = {1'b0, xa} + {1'b0, xb}; r = s[W-1:0]; m_carry = s[W]; end
      4'h1: begin s = {1'b0, xa} + {1'b0, xb} + {16'b0, m_carry}; r = s[W-1:0]; m_carry = s[W]; end
      4'h2: begin r = xa - xb; m_carry = (xa >= xb); end
      4'h3: begin
        bw = !m_carry;
        r = xa - xb - {15'b0, bw};
        m_carry = ({1'b0, xa} >= ({1'b0, xb} + {16'b0, bw}));
      end
      4'h4: r = xa & xb;
      4'h5: r = xa | xb;
      4'h6: r = xa ^ xb;
      4'h7: r = ~xa;
      4'h8: r = (xb >= 16) ? 16'h0 : xa << xb[3:0];
      4'h9: r = (xb >= 16) ? 16'h0 : xa >> xb[3:0];
      4'hA: r = (xb >= 16) ? {16{xa[15]}} : 16'($signed(xa) >>> xb[3:0]);
      4'hB: for (int k = 0; k < int'(xb[3:0]); k++) r = {r[0], r[15:1]};
      4'hC: begin
        p = longint'($signed(xa)) * longint'($signed(xb));
        r = p[15:0]; m_hi = p[31:16]; m_carry = 1'b0;
      end
      4'hD: begin
        p   = longint'($signed(xa)) * longint'($signed(xb));
        cx  = {{16{xc[15]}}, xc};
        s33 = {1'b0, p[31:0]} + {1'b0, cx};
        r = s33[15:0]; m_hi = s33[31:16]; m_carry = s33[32];
      end
      4'hE: r = m_hi;
      default: r = xa;
    endcase
    m_res = r;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, xb, xc);
    exp_t e;
    int   t;
    bit   rdy_low;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin chk("ready_timeout", in_ready, 1); return; end
    model(o, xa, xb, xc, e.res);
    e.cy = m_carry; e.z = (e.res == 0); e.n = e.res[W-1];
    e.lat = (o == 4'hC || o == 4'hD) ? W + 2 : 2;
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b1; op = o; a = xa; b = xb; c = xc;
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom); c = W'($urandom);
    t = 0; rdy_low = 1'b1;
    while (!done && t < 50) begin
      if (in_ready) rdy_low = 1'b0;
      @(negedge clk); t++;
    end
    e = sbq.pop_front();
    if (!done) chk("done_timeout", done, 1);
    else begin
      chk("latency", cyc - e.acc, e.lat);
      chk("result", result, e.res);
      chk("carry", carry, e.cy);
      chk("zero", zero, e.z);
      chk("neg", neg, e.n);
      if (e.lat != 2) chk("ready_in_mul", rdy_low, 1);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  // Starts a MUL and returns once it is in flight, three cycles after accept.
  task automatic start_mul(input logic [W-1:0] xa, xb);
    int t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    in_valid = 1'b1; op = 4'hC; a = xa; b = xb; c = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_no_done(input string tag);
    bit seen = 1'b0;
    repeat (30) begin @(negedge clk); if (done) seen = 1'b1; end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; c = '0;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    issue(4'h0, 16'hFFFF, 16'h0001, 16'h0);
    chk("add_vec", {result, carry, zero}, {16'h0000, 1'b1, 1'b1});
    issue(4'h1, 16'h0001, 16'h0001, 16'h0);
    chk("adc_vec", {result, carry}, {16'h0003, 1'b0});
    issue(4'h2, 16'h0003, 16'h0005, 16'h0);
    chk("sub_vec", {result, carry, neg}, {16'hFFFE, 1'b0, 1'b1});
    issue(4'hC, 16'h8000, 16'h8000, 16'h0);
    chk("mul_min_lo", result, 16'h0000);
    issue(4'hE, 16'h0, 16'h0, 16'h0);
    chk("mul_min_hi", result, 16'h4000);
    issue(4'hC, 16'hFFFD, 16'h0007, 16'h0);
    chk("mul_neg_lo", result, 16'hFFEB);
    issue(4'hE, 16'h0, 16'h0, 16'h0);
    chk("mul_neg_hi", result, 16'hFFFF);
    issue(4'hD, 16'h0010, 16'h0010, 16'hFFFF);
    chk("mla_lo", result, 16'h00FF);
    issue(4'hE, 16'h0, 16'h0, 16'h0);
    chk("mla_hi", result, 16'h0000);
    issue(4'h8, 16'h0001, 16'h0010, 16'h0);
    chk("lsl_big", result, 16'h0000);
    issue(4'hA, 16'h8000, 16'h0014, 16'h0);
    chk("asr_big", result, 16'hFFFF);
    issue(4'hB, 16'h0001, 16'h0011, 16'h0);
    chk("ror_wrap", result, 16'h8000);

    // a MUL sets a known hi, then a flushed MUL must leave it untouched
    issue(4'hC, 16'h0123, 16'h0456, 16'h0);
    start_mul(16'h7FFF, 16'h7FFF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    expect_no_done("flush_no_done");
    chk("flush_result", result, m_res);
    issue(4'hE, 16'h0, 16'h0, 16'h0);

    start_mul(16'h1234, 16'h5678);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_hi = '0; m_carry = 1'b0; m_res = '0;
    chk("mrst_state", {result, carry, zero, neg, done, in_ready},
                      {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    expect_no_done("mrst_no_done");
    issue(4'hE, 16'h0, 16'h0, 16'h0);
    issue(4'h1, 16'h0000, 16'h0000, 16'h0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] rb;
      ro = 4'($urandom_range(0, 15));
      rb = W'($urandom);
      if (ro >= 4'h8 && ro <= 4'hB && $urandom_range(0, 1) == 1) rb = W'($urandom_range(0, 20));
      issue(ro, W'($urandom), rb, W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand/result width; legal range 8..32.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning the number of shift-amount bits used by ROR.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port op, input, 4 bits: operation code (REQ-015).
REQ-008 The block SHALL have ports a, b, c, input, WIDTH bits each: signed operands; c is used only by MLA.
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous abort of an in-flight multiply.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result/flags valid.
REQ-011 The block SHALL have port result, output, WIDTH bits: last completed result, held until the next done.
REQ-012 The block SHALL have ports carry, zero, neg, output, 1 bit each: registered flags.

Function
REQ-013 Handshake: an operation SHALL be accepted on a cycle where in_valid && in_ready; in_ready = (state==IDLE) && !done.
REQ-014 States: IDLE, MUL, DONE. IDLE->DONE for single-cycle ops; IDLE->MUL for MUL/MLA; MUL->DONE after WIDTH iterations; DONE->IDLE always. flush in MUL SHALL go to IDLE with no done and no change to result, flags or hi.
REQ-015 Op codes: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT a, 8 LSL, 9 LSR, A ASR, B ROR, C MUL, D MLA, E MRT, F PASS a.
REQ-016 Latency: single-cycle ops SHALL assert done exactly 2 cycles after acceptance; MUL/MLA SHALL assert done WIDTH+2 cycles after acceptance.
REQ-017 ADD/ADC: {carry,result} = a + b (+carry for ADC), computed in WIDTH+1 unsigned bits.
REQ-018 SUB/SBC: result = a - b (- !carry for SBC); carry = 1 when no borrow occurred (unsigned a >= b + borrow-in).
REQ-019 Logic, shift, ROR, MRT and PASS ops SHALL leave carry unchanged.
REQ-020 Shifts: for LSL/LSR, b >= WIDTH (unsigned) SHALL give 0. For ASR, it SHALL give all bits equal to a[WIDTH-1]. ROR SHALL rotate right by b[SHW-1:0] mod WIDTH.
REQ-021 MUL: the signed 2*WIDTH-bit product a*b SHALL be formed by an internal iterative shift-add on magnitudes, one bit per cycle, with the sign applied at the end; low half goes to result, high half to internal register hi.
REQ-022 MLA: result/hi SHALL be the 2*WIDTH-bit value a*b + sign-extended c; the final add carry-out SHALL go to carry. MUL SHALL clear carry.
REQ-023 MRT SHALL return hi; hi changes only on MUL/MLA completion.
REQ-024 zero = (result==0) and neg = result[WIDTH-1] SHALL update on every done.
REQ-025 Operands SHALL be captured at acceptance; input changes during MUL SHALL NOT affect the result.
REQ-026 MUL with operand -2^(WIDTH-1) SHALL produce the exact signed product (no overflow in magnitude logic).

Reset
REQ-027 With rst_n low, the block SHALL go to IDLE and set result=0, hi=0, carry=0, zero=1, neg=0, done=0; in_ready SHALL be 1 after release.
REQ-028 Reset asserted mid-multiply SHALL abandon it immediately, with no done pulse after release.

Verification
REQ-029 WIDTH=16: ADD a=FFFF, b=0001 -> result 0000, carry 1, zero 1, done 2 cycles after accept.
REQ-030 Check ADC a=0001, b=0001 with carry=1 -> result 0003, carry 0. Then SUB a=0003, b=0005 -> result FFFE, carry 0, neg 1.
REQ-031 MUL a=8000, b=8000 -> done at cycle 18, result 0000; then MRT -> 4000. Also MUL a=FFFD(-3), b=0007 -> result FFEB, hi FFFF.
REQ-032 MLA a=0010, b=0010, c=FFFF -> result 00FF, hi 0000. in_ready SHALL be 0 throughout MUL.
REQ-033 Shifts: LSL a=0001, b=0010 -> 0000. ASR a=8000, b=0014 -> FFFF. ROR a=0001, b=0011 -> 8000.
REQ-034 Start MUL, then pulse flush at cycle 5 -> no done, result/hi unchanged, in_ready 1 the next cycle. Repeat with rst_n pulsed low instead -> reset values per REQ-027.
